// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin arbiter sharing one W-bit AND unit among
// N_REQ requesters, with a valid/ready request handshake.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, IDLE only)
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, requester i at [i*W +: W]
//   rsp_valid  one-hot result strobe, one cycle
//   rsp_data   captured result, held until next capture
//   gate_a     operand A to shared AND unit
//   gate_b     operand B to shared AND unit
//   gate_y     result from shared AND unit
//   busy       high while settling or responding
//   err        sticky result-mismatch flag (ARB_SELFCHECK_EN builds only)
//
// Optional feature macro: ARB_SELFCHECK_EN adds the err port and comparator.

module and_share_arbiter #(
   parameter int N_REQ  = 4,
   parameter int W      = 8,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [W-1:0]       rsp_data,
   output logic [W-1:0]       gate_a,
   output logic [W-1:0]       gate_b,
   input  logic [W-1:0]       gate_y,
   output logic               busy
`ifdef ARB_SELFCHECK_EN
  ,output logic               err
`endif
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(SETTLE + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic [CW-1:0] cnt;

   logic [IW-1:0] win;
   logic          found;
   logic [IW:0]   sum;
   logic          hs;
   logic [IW-1:0] rr_next;

   // Rotating priority search starting at rr_ptr; first valid requester wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ))
            sum = sum - (IW+1)'(N_REQ);
         if (!found && req_valid[sum[IW-1:0]]) begin
            found = 1'b1;
            win   = sum[IW-1:0];
         end
      end
   end

   assign hs = (state == S_IDLE) && found;

   // Ready is suppressed while reset is held so outputs read zero.
   always_comb begin
      req_ready = '0;
      if (hs && !rst)
         req_ready[win] = 1'b1;
   end

   always_comb begin
      rsp_valid = '0;
      if (state == S_RESP)
         rsp_valid[grant] = 1'b1;
   end

   assign busy = (state == S_SETTLE) || (state == S_RESP);

   assign rr_next = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         cnt      <= '0;
         gate_a   <= '0;
         gate_b   <= '0;
         rsp_data <= '0;
`ifdef ARB_SELFCHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (hs) begin
                  gate_a <= req_a[win*W +: W];
                  gate_b <= req_b[win*W +: W];
                  grant  <= win;
                  cnt    <= CW'(SETTLE - 1);
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  rsp_data <= gate_y;
                  state    <= S_RESP;
`ifdef ARB_SELFCHECK_EN
                  if (gate_y != (gate_a & gate_b))
                     err <= 1'b1;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               rr_ptr <= rr_next;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
